// File: rtl/ma_mem_bridge_pkg.sv
// Shared encodings for the MA data-memory bridge: FSM states and bus size codes.
// The size helper clamps out-of-range MA size requests to a word access.
package ma_mem_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [1:0] size_map(input logic [2:0] mem_size);
    logic [1:0] code;
    code = SIZE_W;
    if (mem_size <= 3'd2) code = mem_size[1:0];
    return code;
  endfunction

endpackage

// File: rtl/ma_mem_bridge_req_buf.sv
// Bus payload latch: captures one MA request on i_load and holds it stable
// on the bus until the next load; zero-latency outputs straight from registers.
module ma_mem_bridge_req_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_p,
  input  logic                i_load,
  input  logic                i_wr,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [1:0]          i_size,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_wr,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [1:0]          o_size,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic [DATA_W-1:0]   o_wdata
);

  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_wdata;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_wr    <= i_wr;
      r_addr  <= i_addr;
      r_size  <= i_size;
      r_wstrb <= i_wstrb;
      r_wdata <= i_wdata;
    end
  end

  assign o_wr    = r_wr;
  assign o_addr  = r_addr;
  assign o_size  = r_size;
  assign o_wstrb = r_wstrb;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/ma_mem_bridge.sv
// MA-stage data-memory responder onto a req/addr_ok/data_ok bus, one transaction outstanding.
// Read pulse at T -> data_req at T+1 -> rdata_valid at T+3 best case; MA stalls on mem_busy.
module ma_mem_bridge
  import ma_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_p,
  input  logic                i_flush,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [DATA_W/8-1:0] i_mem_wstrb,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [2:0]          i_mem_size,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  output logic                o_interlayer_ready,
  output logic                o_mem_busy,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rdata_valid,
  output logic                o_data_req,
  output logic                o_data_wr,
  output logic [1:0]          o_data_size,
  output logic [ADDR_W-1:0]   o_data_addr,
  output logic [DATA_W/8-1:0] o_data_wstrb,
  output logic [DATA_W-1:0]   o_data_wdata,
  input  logic                i_data_addr_ok,
  input  logic                i_data_data_ok,
  input  logic [DATA_W-1:0]   i_data_rdata
);

  logic [1:0]        r_state;
  logic              r_drop;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;

  logic              w_idle;
  logic              w_take_wr;
  logic              w_take_rd;
  logic              w_load;
  logic [1:0]        w_size;
  logic              w_buf_wr;
  logic              w_resp_done;
  logic              w_deliver;

  // Write has priority; a simultaneous read is dropped (MA never does this).
  assign w_idle      = (r_state == ST_IDLE);
  assign w_take_wr   = w_idle & i_mem_write;
  assign w_take_rd   = w_idle & ~i_mem_write & i_mem_read;
  assign w_load      = w_take_wr | w_take_rd;
  assign w_size      = size_map(i_mem_size);
  assign w_resp_done = (r_state == ST_RESP) & i_data_data_ok;
  assign w_deliver   = w_resp_done & ~w_buf_wr & ~r_drop & ~i_flush;

  ma_mem_bridge_req_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_buf (
    .clk     (clk),
    .rst_p   (rst_p),
    .i_load  (w_load),
    .i_wr    (w_take_wr),
    .i_addr  (i_mem_addr),
    .i_size  (w_size),
    .i_wstrb (i_mem_wstrb),
    .i_wdata (i_mem_wdata),
    .o_wr    (w_buf_wr),
    .o_addr  (o_data_addr),
    .o_size  (o_data_size),
    .o_wstrb (o_data_wstrb),
    .o_wdata (o_data_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_state       <= ST_IDLE;
      r_drop        <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_deliver;
      if (w_deliver) r_rdata <= i_data_rdata;

      // data_ok seen alongside addr_ok is ignored: the slave never does that.
      case (r_state)
        ST_IDLE: if (w_load) r_state <= ST_REQ;
        ST_REQ:  if (i_data_addr_ok) r_state <= ST_RESP;
        ST_RESP: if (i_data_data_ok) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Stores always land; only an in-flight read can be discarded.
      if (w_take_rd) begin
        r_drop <= 1'b0;
      end else if (!w_idle && !w_buf_wr && i_flush) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign o_interlayer_ready = w_idle;
  assign o_mem_busy         = ~w_idle;
  assign o_data_req         = (r_state == ST_REQ);
  assign o_data_wr          = w_buf_wr;
  assign o_rdata            = r_rdata;
  assign o_rdata_valid      = r_rdata_valid;

endmodule
